axis_out_ctrl: RTL and testbench
================================

Name: axis_out_ctrl

Overview:
- AXI-Stream master (transmitter) that returns results from the core to the host DMA.
- Captures one N-character result vector from the core in a single cycle.
- Emits the vector as N beats on M_AXIS, asserting TLAST on beat N-1.
- Output-side counterpart of the slave-side stream input controller; sits between the core's finish/result outputs and the top-level M_AXIS port.

Parameters:
- N, default `N (consts.vh): characters per frame (beats per packet); must be >= 1.
- CHAR_LEN, default `CHAR_LEN (consts.vh): bits per character (TDATA width).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  asynchronous active-high reset.
- load  in  1  one-cycle request from core to capture d and start a packet.
- d  in  N*CHAR_LEN  result vector; character i = d[i*CHAR_LEN +: CHAR_LEN].
- ready  out  1  high when idle and able to accept load.
- done  out  1  one-cycle pulse after the last beat handshakes.
- M_AXIS_TDATA  out  CHAR_LEN  current character.
- M_AXIS_TLAST  out  1  high on beat N-1 only.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, ARESET=1):
  - state=IDLE, idx=0, buffer cleared to 0.
  - Outputs: ready=1, done=0, TVALID=0, TLAST=0, TDATA=0.
  - Reset asserted mid-packet aborts the packet immediately; no done pulse is produced.
- States:
  - IDLE: ready=1, TVALID=0. load=1 at edge k: buf[i] <= d[i*CHAR_LEN +: CHAR_LEN] for all i, idx <= 0, state <= SEND, ready <= 0.
  - SEND: TVALID=1, TDATA=buf[idx], TLAST=(idx==N-1).
    - Handshake = TVALID & TREADY at a rising edge.
    - On handshake with idx<N-1: idx <= idx+1.
    - On handshake with idx==N-1: state <= DONE.
    - No handshake: all outputs hold.
  - DONE: TVALID=0, TLAST=0, done=1 for exactly this cycle. Next edge: state <= IDLE, ready <= 1.
- Latency:
  - load at edge k gives TVALID=1 with character 0 from cycle k+1.
  - With TREADY held high, beat j transfers at edge k+1+j.
  - done is high in cycle k+N+1; ready returns in cycle k+N+2.
- AXI-Stream rules:
  - TVALID never depends combinationally on TREADY.
  - Once TVALID is high, TDATA and TLAST are stable until the handshake.
  - TVALID drops only after the TLAST beat is accepted.
  - TREADY is ignored outside SEND.
- Buffer: d is sampled only on the accepted load edge; changes to d afterwards do not affect the packet in flight.
- load while not IDLE (SEND or DONE): ignored, no error, no queueing.
- load held high continuously: a new packet starts on the first IDLE cycle, i.e. back-to-back packets separated by one DONE cycle and one IDLE cycle.
- idx width: $clog2(N), minimum 1 bit. idx never exceeds N-1.
- N=1: the single beat carries TLAST=1.
- TDATA in IDLE/DONE: holds the last value; not relied upon.

Test Plan (N=4, CHAR_LEN=8 overrides):
1. Reset, then load with d=32'h44332211 and TREADY=1 throughout -> TDATA 11,22,33,44 on consecutive edges; TLAST only on 44; done pulse one cycle after the 44 handshake; ready=1 one cycle later.
2. Same load, TREADY=0 for 3 cycles, then toggling 1,0,1,... -> TVALID stays 1; TDATA=11 held while stalled; every beat delivered exactly once in order; TLAST only with 44.
3. load while in SEND carrying d=32'hDDCCBBAA -> ignored; the current packet completes unchanged; no second packet appears.
4. Change d on the cycle after load -> the transmitted beats still equal the captured 11,22,33,44.
5. Assert ARESET during beat 2 -> TVALID, TLAST and done drop at once with no done pulse; ready=1; a new load then sends a full 4-beat packet from character 0.
6. load held high with TREADY=1 -> two back-to-back packets; TVALID low for exactly 2 cycles between the TLAST beat and the first beat of the next packet.

Source files
------------

// File: rtl/axis_out_ctrl.sv
// AXI-Stream master that returns one captured N-character result vector
// as an N-beat packet with TLAST on the final beat, then pulses done.
module axis_out_ctrl #(
  parameter int N        = 4,
  parameter int CHAR_LEN = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  load,
  input  logic [N*CHAR_LEN-1:0] d,
  output logic                  ready,
  output logic                  done,
  output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [IDXW-1:0]       idx_reg, idx_next;
  logic [N*CHAR_LEN-1:0] buf_reg;
  logic                  capture;
  logic [CHAR_LEN-1:0]   chars [N];

  // d is sampled only on the accepted load edge, so later changes on d
  // never disturb a packet in flight.
  assign capture = (state_reg == S_IDLE) && load;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (load) begin
          state_next = S_SEND;
          idx_next   = '0;
        end
      end
      S_SEND: begin
        if (M_AXIS_TREADY) begin
          if (idx_reg == IDX_LAST) state_next = S_DONE;
          else                     idx_next   = idx_reg + IDXW'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (capture) buf_reg <= d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chars
      assign chars[gi] = buf_reg[gi*CHAR_LEN +: CHAR_LEN];
    end
  endgenerate

  // All outputs decode registered state only; TVALID never looks at TREADY.
  assign ready         = (state_reg == S_IDLE);
  assign done          = (state_reg == S_DONE);
  assign M_AXIS_TVALID = (state_reg == S_SEND);
  assign M_AXIS_TLAST  = (state_reg == S_SEND) && (idx_reg == IDX_LAST);
  assign M_AXIS_TDATA  = chars[idx_reg];

endmodule

// File: tb/tb_axis_out_ctrl.sv
// Self-checking bench for axis_out_ctrl (N=4, CHAR_LEN=8): per-cycle vector
// table plus hand-written stall/abort/back-to-back sequences with a beat scoreboard.
module tb_axis_out_ctrl;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          load;
  logic [N*CW-1:0] d;
  logic          ready, done;
  logic [CW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;

  axis_out_ctrl #(.N(N), .CHAR_LEN(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .load(load), .d(d),
    .ready(ready), .done(done),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [CW:0] exp_q [$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push_pkt(input logic [N*CW-1:0] dv);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), dv[i*CW +: CW]});
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (!(ready === 1'b1 && exp_q.size() == 0) && c < 60) begin
      tick();
      c++;
    end
    check({nm, "_idle_reached"}, 32'(c < 60), 32'd1);
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle: a beat seen valid&ready
  // here is the one that transfers at the coming rising edge.
  logic        prev_stall = 1'b0;
  logic [CW:0] prev_beat;
  always @(negedge ACLK) begin
    logic [CW:0] e;
    if (ARESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid_held", 32'(M_AXIS_TVALID), 32'd1);
        check("stall_beat_held", 32'({M_AXIS_TLAST, M_AXIS_TDATA}), 32'(prev_beat));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({M_AXIS_TLAST, M_AXIS_TDATA}), 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("beat_last_data", 32'({M_AXIS_TLAST, M_AXIS_TDATA}), 32'(e));
          $display("[TB] beat data=%02h last=%0b", M_AXIS_TDATA, M_AXIS_TLAST);
        end
      end
      if (done) done_cnt++;
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_beat  = {M_AXIS_TLAST, M_AXIS_TDATA};
    end
  end

  typedef struct {
    logic        load;
    logic [31:0] d;
    logic        tready;
    logic        e_ready;
    logic        e_valid;
    logic        e_last;
    logic        e_done;
    logic [7:0]  e_data;
    logic        chk_data;
  } vec_t;

  vec_t vecs [6];
  logic v_hist [16];

  initial begin
    int ones, gap, first_fall, c;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, gap, c;
    bit seen_one, in_gap, gap_done;

    //            load d             trdy rdy vld lst dn data  chk
    vecs[0] = '{1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
    vecs[1] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1};
    vecs[2] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1};
    vecs[3] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1};
    vecs[4] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    ARESET = 1'b1; load = 1'b0; d = '0; M_AXIS_TREADY = 1'b0;
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    check("rst_tdata", 32'(M_AXIS_TDATA), 32'd0);
    tick();
    ARESET = 1'b0;
    tick();

    // 1: table-driven full packet with TREADY high
    push_pkt(32'h44332211);
    exp_done++;
    for (int r = 0; r < 6; r++) begin
      load = vecs[r].load; d = vecs[r].d; M_AXIS_TREADY = vecs[r].tready;
      tick();
      check($sformatf("t1_r%0d_ready", r), 32'(ready), 32'(vecs[r].e_ready));
      check($sformatf("t1_r%0d_tvalid", r), 32'(M_AXIS_TVALID), 32'(vecs[r].e_valid));
      check($sformatf("t1_r%0d_tlast", r), 32'(M_AXIS_TLAST), 32'(vecs[r].e_last));
      check($sformatf("t1_r%0d_done", r), 32'(done), 32'(vecs[r].e_done));
      if (vecs[r].chk_data)
        check($sformatf("t1_r%0d_tdata", r), 32'(M_AXIS_TDATA), 32'(vecs[r].e_data));
    end
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_done_count", 32'(done_cnt), 32'(exp_done));

    // 2: stall three cycles then toggle TREADY
    load = 1'b1; d = 32'h44332211; M_AXIS_TREADY = 1'b0;
    push_pkt(32'h44332211);
    exp_done++;
    tick();
    load = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t2_stall%0d_tvalid", s), 32'(M_AXIS_TVALID), 32'd1);
      check($sformatf("t2_stall%0d_tdata", s), 32'(M_AXIS_TDATA), 32'h11);
      tick();
    end
    c = 0;
    while (exp_q.size() != 0 && c < 40) begin
      M_AXIS_TREADY = ~M_AXIS_TREADY;
      tick();
      c++;
    end
    M_AXIS_TREADY = 1'b1;
    wait_idle("t2");
    check("t2_done_count", 32'(done_cnt), 32'(exp_done));

    // 3: load during SEND with other data is ignored
    load = 1'b1; d = 32'h44332211;
    push_pkt(32'h44332211);
    exp_done++;
    tick();
    d = 32'hDDCCBBAA;
    tick();
    load = 1'b0;
    wait_idle("t3");
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("t3_quiet%0d_tvalid", s), 32'(M_AXIS_TVALID), 32'd0);
    end
    check("t3_done_count", 32'(done_cnt), 32'(exp_done));

    // 4: d changes right after capture
    load = 1'b1; d = 32'h44332211;
    push_pkt(32'h44332211);
    exp_done++;
    tick();
    load = 1'b0; d = 32'hDEADBEEF;
    wait_idle("t4");
    check("t4_done_count", 32'(done_cnt), 32'(exp_done));

    // 5: reset during beat 2 aborts the packet
    load = 1'b1; d = 32'h44332211;
    push_pkt(32'h44332211);
    tick();
    load = 1'b0;
    tick();
    tick();
    check("t5_pre_tdata", 32'(M_AXIS_TDATA), 32'h33);
    ARESET = 1'b1;
    #1;
    check("t5_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("t5_rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd1);
    exp_q.delete();
    tick();
    ARESET = 1'b0;
    tick();
    load = 1'b1; d = 32'h44332211;
    push_pkt(32'h44332211);
    exp_done++;
    tick();
    load = 1'b0;
    check("t5_restart_tdata", 32'(M_AXIS_TDATA), 32'h11);
    wait_idle("t5");
    check("t5_done_count", 32'(done_cnt), 32'(exp_done));

    // 6: load held high gives back-to-back packets with a 2-cycle gap
    load = 1'b1; d = 32'h44332211; M_AXIS_TREADY = 1'b1;
    push_pkt(32'h44332211);
    push_pkt(32'h44332211);
    exp_done += 2;
    for (int s = 0; s < 16; s++) begin
      tick();
      v_hist[s] = M_AXIS_TVALID;
      if (s == 6) load = 1'b0;
    end
    ones = 0; gap = 0; seen_one = 0; in_gap = 0; gap_done = 0;
    for (int s = 0; s < 16; s++) begin
      if (v_hist[s]) begin
        ones++;
        if (in_gap) gap_done = 1;
        seen_one = 1;
        in_gap = 0;
      end else if (seen_one && !gap_done) begin
        in_gap = 1;
        gap++;
      end
    end
    check("t6_valid_beats", 32'(ones), 32'd8);
    check("t6_gap_cycles", 32'(gap), 32'd2);
    wait_idle("t6");
    check("t6_done_count", 32'(done_cnt), 32'(exp_done));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
